layer_input_feeder: RTL

//  Upstream/downstream partner of a neural-network layer block: collects N signed fixed-point

---
 rtl/nn_pkg.sv | 19 +
 rtl/layer_input_feeder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/nn_pkg.sv
// -----------------------------------------------------------------------------
// nn_pkg
// Shared definitions for the neural-network layer chain.
//   feeder_state_t : states of the layer input feeder (FILL, REQ, FLUSH)
//   FRAC_BITS      : fractional bits of the Q(W-4).4 activation format
//   DATA_W         : default activation width
// -----------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } feeder_state_t;

    localparam int FRAC_BITS = 4;
    localparam int DATA_W    = 8;

endpackage : nn_pkg

// File: rtl/layer_input_feeder.sv
// -----------------------------------------------------------------------------
// layer_input_feeder
// Collects N signed activations from a producer stream, presents them to a
// layer through an address-indexed read port while the layer computes,
// captures the layer's result on ack_layer, then resets the layer for one
// cycle so it is ready for the next vector.
//
// Ports
//   clk        in   1   clock, all logic on posedge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   producer offers in_data
//   in_data    in   W   activation, signed
//   in_ready   out  1   feeder accepts in_data (transfer = in_valid & in_ready)
//   req        out  1   input vector complete and stable
//   addr       in   AW  layer's input-select address
//   rd_data    out  W   mem[addr], combinational; 0 when addr >= N
//   ack_layer  in   1   layer result valid (sticky until layer reset)
//   layer_val  in   W   layer result value
//   layer_rst  out  1   synchronous reset to the layer
//   result     out  W   captured layer result
//   done       out  1   one-cycle pulse: result updated
// -----------------------------------------------------------------------------
module layer_input_feeder
    import nn_pkg::*;
#(
    parameter int N  = 2,
    parameter int W  = DATA_W,
    parameter int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          req,
    input  logic [AW-1:0] addr,
    output logic [W-1:0]  rd_data,
    input  logic          ack_layer,
    input  logic [W-1:0]  layer_val,
    output logic          layer_rst,
    output logic [W-1:0]  result,
    output logic          done
);

    // N widened by one bit so the range compare also works when N is a power of 2.
    localparam logic [AW:0]   N_EXT    = (AW+1)'(N);
    localparam logic [AW-1:0] LAST_PTR = AW'(N - 1);

    feeder_state_t r_state;
    feeder_state_t w_next_state;

    logic [W-1:0]  r_mem [N];
    logic [AW-1:0] r_wr_ptr;
    logic [W-1:0]  r_result;
    logic          r_done;

    logic w_transfer;
    logic w_last_word;
    logic w_capture;
    logic w_flush;

    assign w_transfer  = in_valid & in_ready;
    assign w_last_word = (r_wr_ptr == LAST_PTR);
    // Acks seen outside REQ are stale leftovers from the previous vector.
    assign w_capture   = (r_state == REQ) & ack_layer;

    // Next-state and Moore outputs.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        req          = 1'b0;
        w_flush      = 1'b0;
        case (r_state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && w_last_word) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (ack_layer) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                w_flush      = 1'b1;
                w_next_state = FILL;
            end
            default: begin
                w_next_state = FILL;
            end
        endcase
    end

    // State, write pointer and result capture.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= FILL;
            r_wr_ptr <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_capture;
            if (w_capture) begin
                r_result <= layer_val;
            end
            if (w_transfer) begin
                r_wr_ptr <= w_last_word ? '0 : r_wr_ptr + 1'b1;
            end
        end
    end

    // Activation storage.
    // NOTE: the array is deliberately left out of reset; its contents are
    // always rewritten in FILL before req exposes them to the layer.
    always_ff @(posedge clk) begin
        if (w_transfer) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, addr} < N_EXT) begin
            rd_data = r_mem[addr];
        end
    end

    // Combinational so the layer is held in reset together with the feeder.
    assign layer_rst = rst | w_flush;
    assign result    = r_result;
    assign done      = r_done;

endmodule : layer_input_feeder
